// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared constants and state encoding for the Hack MUL extension
package hack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } mul_state_t;

    // ALU control word {zx, nx, zy, ny, f, no}: plain x+y
    localparam logic [5:0] ALU_CTRL_ADD = 6'b000010;

    localparam int MUL_ITERS = 16;

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - 16-bit Hack ALU
//
// Ports:
//   x, y          16-bit operands
//   zx, nx        zero / negate x before the function
//   zy, ny        zero / negate y before the function
//   f             1: x+y, 0: x&y
//   no            negate the function result
//   out           16-bit result
//   zr            out == 0
//   ng            out[15]
module ALU (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z, x_n, y_z, y_n, fx;

    always_comb begin
        x_z = zx ? 16'd0 : x;
        x_n = nx ? ~x_z : x_z;
        y_z = zy ? 16'd0 : y;
        y_n = ny ? ~y_z : y_z;
        fx  = f ? (x_n + y_n) : (x_n & y_n);
        out = no ? ~fx : fx;
        zr  = (out == 16'd0);
        ng  = out[15];
    end

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add 16x16 multiplier sequenced through one Hack ALU
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   start    request, sampled only when not busy
//   a, b     multiplicand / multiplier, captured on accepted start
//   busy     operation in progress
//   done     one-cycle pulse, product/zr/ng valid
//   product  low 16 bits of a*b, held until the next completion
//   zr, ng   product == 0, product[15]
//
// Optional feature: define MUL_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero (data-dependent latency).
module alu_mul_seq
    import hack_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        zr,
    output logic        ng
);

    mul_state_t  state, state_next;
    logic [15:0] acc, mc, mp;
    logic [3:0]  cnt;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zr_unused, alu_ng_unused;
    logic        accept;
    logic        last_iter;
    logic [15:0] mp_shifted;
    logic [15:0] result;

    assign accept     = start && (state == IDLE || state == DONE);
    assign mp_shifted = {1'b0, mp[15:1]};
    assign busy       = (state == ADD) || (state == SHIFT);
    assign done       = (state == DONE);

`ifdef MUL_EARLY_EXIT_EN
    assign last_iter = (mp_shifted == 16'd0) || (cnt == 4'(MUL_ITERS - 1));
`else
    assign last_iter = (cnt == 4'(MUL_ITERS - 1));
`endif

    // ADD accumulates the multiplicand; SHIFT doubles it by adding it to itself
    always_comb begin
        alu_x = (state == ADD) ? acc : mc;
        alu_y = mc;
    end

    ALU u_alu (
        .x   (alu_x),
        .y   (alu_y),
        .zx  (ALU_CTRL_ADD[5]),
        .nx  (ALU_CTRL_ADD[4]),
        .zy  (ALU_CTRL_ADD[3]),
        .ny  (ALU_CTRL_ADD[2]),
        .f   (ALU_CTRL_ADD[1]),
        .no  (ALU_CTRL_ADD[0]),
        .out (alu_out),
        .zr  (alu_zr_unused),
        .ng  (alu_ng_unused)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
`ifdef MUL_EARLY_EXIT_EN
                    state_next = (b == 16'd0) ? DONE : ADD;
`else
                    state_next = ADD;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            ADD:     state_next = SHIFT;
            SHIFT:   state_next = last_iter ? DONE : ADD;
            default: state_next = IDLE;
        endcase
    end

    // DONE is entered either from SHIFT (acc holds the final sum) or directly
    // from an accepted start with b==0, where the product is zero
    assign result = (state == SHIFT) ? acc : 16'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= 16'd0;
            mc      <= 16'd0;
            mp      <= 16'd0;
            cnt     <= 4'd0;
            product <= 16'd0;
            zr      <= 1'b1;
            ng      <= 1'b0;
        end else begin
            if (accept) begin
                acc <= 16'd0;
                mc  <= a;
                mp  <= b;
                cnt <= 4'd0;
            end else if (state == ADD) begin
                if (mp[0]) begin
                    acc <= alu_out;
                end
            end else if (state == SHIFT) begin
                mc  <= alu_out;
                mp  <= mp_shifted;
                cnt <= cnt + 4'd1;
            end

            if (state_next == DONE) begin
                product <= result;
                zr      <= (result == 16'd0);
                ng      <= result[15];
            end
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - directed-vector bench for alu_mul_seq
module tb_alu_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        zr;
    logic        ng;

    int n_vec;
    int n_err;

    alu_mul_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zr      (zr),
        .ng      (ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] bv);
`ifdef MUL_EARLY_EXIT_EN
        int m;
        m = 0;
        for (int i = 0; i < 16; i++) begin
            if (bv[i]) m = i + 1;
        end
        return 2 * m;
`else
        return 32;
`endif
    endfunction

    // Cycles counted from E0 (+1 time unit) until done is seen high.
    task automatic wait_done(input string tag, output int lat, output logic held);
        logic [15:0] prev;
        prev = product;
        held = 1'b1;
        lat  = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done && product !== prev) held = 1'b0;
        end
        if (!done) $display("FAIL %s_timeout: done not seen within 40 cycles", tag);
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [15:0] exp_p);
        int   lat;
        logic held;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(tag, lat, held);
        check({tag, "_lat"}, lat, exp_lat(tb_v));
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_prod"}, {16'd0, product}, {16'd0, exp_p});
        check({tag, "_zr"}, {31'd0, zr}, {31'd0, exp_p == 16'd0});
        check({tag, "_ng"}, {31'd0, ng}, {31'd0, exp_p[15]});
        check({tag, "_held"}, {31'd0, held}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int   lat;
        logic held;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        a     = 16'd0;
        b     = 16'd0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_prod", {16'd0, product}, 32'd0);
        check("rst_zr", {31'd0, zr}, 32'd1);
        check("rst_ng", {31'd0, ng}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("m3x5", 16'd3, 16'd5, 16'h000F);
        run_op("mffffx2", 16'hFFFF, 16'h0002, 16'hFFFE);
        run_op("wrap", 16'h0100, 16'h0100, 16'h0000);
        run_op("m1234x1", 16'h1234, 16'h0001, 16'h1234);
        run_op("bzero", 16'h5555, 16'h0000, 16'h0000);
        run_op("msb", 16'h0003, 16'h8000, 16'h8000);
        run_op("neg", 16'hFFFD, 16'h0007, 16'hFFEB);

        // start re-pulsed at E5 with different operands is ignored
        @(negedge clk);
        a = 16'd3; b = 16'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy_e0", {31'd0, busy}, 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        a = 16'd9; b = 16'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 5;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ign_lat", lat, exp_lat(16'd5));
        check("ign_prod", {16'd0, product}, 32'h000F);

        // back-to-back: start held during DONE is accepted at E33
        a = 16'd2; b = 16'hC000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        wait_done("b2b", lat, held);
        check("b2b_lat", lat, exp_lat(16'hC000));
        check("b2b_prod", {16'd0, product}, 32'h8000);
        check("b2b_held", {31'd0, held}, 32'd1);

        // asynchronous reset mid-operation, then a clean operation
        @(negedge clk);
        a = 16'd5; b = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_prod", {16'd0, product}, 32'd0);
        check("arst_zr", {31'd0, zr}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        run_op("m7x6", 16'd7, 16'd6, 16'h002A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
